// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory controller: sequencer states,
// grant owners and word geometry.
package imem_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  // The value doubles as the request/grant bit index used by the arbiter
  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_LD    = 1'b1
  } gnt_owner_t;

endpackage

// File: rtl/imem_if.sv
// Fetch, loader and byte-memory signal bundle for imem_ctrl.
// The controller connects through the slave modport.
interface imem_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [31:0]       fetch_inst;
  logic              fetch_err;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_ready;
  logic              ld_done;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, mem_rdata,
    output fetch_ready, fetch_valid, fetch_inst, fetch_err,
           ld_ready, ld_done, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, mem_rdata,
    input  fetch_ready, fetch_valid, fetch_inst, fetch_err,
           ld_ready, ld_done, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/imem_rr_arb.sv
// Two-requester round-robin arbiter. The last-granted pointer resets to the
// loader, so the fetch port wins the first contested cycle.
module imem_rr_arb
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  gnt_owner_t last;

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == GNT_LD) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= GNT_LD;
    end else if (en && (gnt != 2'b00)) begin
      last <= gnt[GNT_LD] ? GNT_LD : GNT_FETCH;
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// Arbitrates the byte-wide instruction memory between word fetches and
// loader word writes (split MSB-first into four byte writes).
// Optional IMEM_HALT_ON_ZERO_EN: a fetched zero word sets a sticky halt.
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  imem_if.slave  bus,
  output logic   halt
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - BYTES_PER_WORD);

  state_t            state;
  logic [1:0]        bcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              ld_ok_q;
  logic              halt_q;
  logic              idle;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              fetch_ok;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_WORD);
  endfunction

  // Gating with rst_n keeps both ready outputs low while reset is held
  assign idle     = (state == IDLE) && rst_n;
  assign req      = {bus.ld_valid & idle, bus.fetch_req & idle & ~halt_q};
  assign fetch_ok = addr_ok(bus.fetch_addr);

  imem_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (idle),
    .gnt   (gnt)
  );

  assign bus.fetch_ready = gnt[GNT_FETCH];
  assign bus.ld_ready    = gnt[GNT_LD];

  always_comb begin
    bus.mem_addr  = bus.fetch_addr;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (state == WRITE) begin
      bus.mem_addr = addr_q + ADDR_W'(bcnt);
      bus.mem_we   = ld_ok_q;
      unique case (bcnt)
        2'd0:    bus.mem_wdata = data_q[31:24];
        2'd1:    bus.mem_wdata = data_q[23:16];
        2'd2:    bus.mem_wdata = data_q[15:8];
        default: bus.mem_wdata = data_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bcnt            <= '0;
      addr_q          <= '0;
      data_q          <= '0;
      ld_ok_q         <= 1'b0;
      bus.fetch_valid <= 1'b0;
      bus.fetch_inst  <= '0;
      bus.fetch_err   <= 1'b0;
      bus.ld_done     <= 1'b0;
    end else begin
      bus.fetch_valid <= 1'b0;
      bus.ld_done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt[GNT_FETCH]) begin
            bus.fetch_valid <= 1'b1;
            bus.fetch_inst  <= fetch_ok ? bus.mem_rdata : '0;
            bus.fetch_err   <= ~fetch_ok;
          end else if (gnt[GNT_LD]) begin
            addr_q  <= bus.ld_addr;
            data_q  <= bus.ld_data;
            ld_ok_q <= addr_ok(bus.ld_addr);
            bcnt    <= '0;
            state   <= WRITE;
          end
        end
        WRITE: begin
          bcnt <= bcnt + 2'd1;
          // Registered one cycle early so ld_done coincides with the last byte
          if (bcnt == 2'd2) bus.ld_done <= 1'b1;
          if (bcnt == 2'd3) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_HALT_ON_ZERO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else if (gnt[GNT_FETCH] && fetch_ok && (bus.mem_rdata == 32'h0000_0000)) begin
      halt_q <= 1'b1;
    end
  end
`else
  assign halt_q = 1'b0;
`endif

  assign halt = halt_q;

endmodule
